// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
//
// Iterative AES-128 round sequencer. Accepts one 128-bit block per
// transaction, keeps the cipher state in a register and walks it through the
// initial AddRoundKey plus 10 rounds. The rounds are computed by an external,
// shared combinational datapath. This block is the only master of that
// datapath. Round keys are pulled one at a time from the key schedule over a
// request/valid handshake.
//
// Optional feature macro: AES_CTRL_DEC_EN
//   defined   : in_mode selects encrypt (0) or decrypt (1).
//   undefined : in_mode is ignored. Every block is encrypted, rk_idx counts
//               upward and dp_inv stays 0.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input block handshake; in_mode and in_data are
//                        sampled when the block is accepted
//   out_valid/out_ready  result handshake; out_data is the state register
//   busy                 high in every state except IDLE
//   rk_req/rk_idx        round-key request and index (0..10)
//   rk_valid/rk_data     round-key response
//   dp_state/dp_key      datapath operands (state register, rk_data)
//   dp_inv/dp_last       datapath controls: inverse round, final round
//   dp_result            combinational datapath output
//
// Byte k of every 128-bit bus occupies bits [8k:8k+7]. The bytes are in
// column-major order.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module aes_round_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [0:127] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy,
  output logic         rk_req,
  output logic [3:0]   rk_idx,
  input  logic         rk_valid,
  input  logic [0:127] rk_data,
  output logic [0:127] dp_state,
  output logic [0:127] dp_key,
  output logic         dp_inv,
  output logic         dp_last,
  input  logic [0:127] dp_result
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARK   = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [3:0] LAST_RND = 4'd10;

`ifdef AES_CTRL_DEC_EN
  localparam logic DEC_EN = 1'b1;
`else
  // Decrypt requests are processed as encrypt, so mode is always 0.
  localparam logic DEC_EN = 1'b0;
`endif

  logic [1:0]   fsm_q,   fsm_d;
  logic [0:127] state_q, state_d;
  logic [3:0]   rnd_q,   rnd_d;
  logic         mode_q,  mode_d;

  logic         key_phase;
  logic         accept;

  // The key-fetch phases. rk_req and rk_idx depend only on registers, so
  // rk_valid has no combinational path to them.
  assign key_phase = (fsm_q == ST_ARK) || (fsm_q == ST_ROUND);

  // in_ready depends on out_ready only in DONE. That lets a new block be
  // accepted in the same cycle as the result is consumed.
  assign in_ready  = (fsm_q == ST_IDLE) || ((fsm_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;

  assign out_valid = (fsm_q == ST_DONE);
  assign out_data  = state_q;
  assign busy      = (fsm_q != ST_IDLE);

  // In ARK rnd is 0, so one expression gives 0 or 10 there. In ROUND it
  // gives the ascending or descending schedule.
  assign rk_req    = key_phase;
  assign rk_idx    = key_phase ? (mode_q ? (LAST_RND - rnd_q) : rnd_q) : 4'd0;

  assign dp_state  = state_q;
  assign dp_key    = rk_data;
  assign dp_inv    = key_phase && mode_q;
  assign dp_last   = (fsm_q == ST_ROUND) && (rnd_q == LAST_RND);

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    mode_d  = mode_q;
    case (fsm_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = in_data;
          mode_d  = in_mode & DEC_EN;
          rnd_d   = 4'd0;
          fsm_d   = ST_ARK;
        end
      end
      ST_ARK: begin
        if (rk_valid) begin
          state_d = state_q ^ rk_data;
          rnd_d   = 4'd1;
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        // Without rk_valid, state, rnd and the key request all hold.
        if (rk_valid) begin
          state_d = dp_result;
          if (rnd_q == LAST_RND) begin
            fsm_d = ST_DONE;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            // The result is consumed and the next block is accepted in the
            // same cycle, so back-to-back blocks take 12 cycles each.
            state_d = in_data;
            mode_d  = in_mode & DEC_EN;
            rnd_d   = 4'd0;
            fsm_d   = ST_ARK;
          end else begin
            fsm_d = ST_IDLE;
          end
        end
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  // A reset abandons any block in flight. Every output is decoded from these
  // registers, so the outputs take their idle values as soon as rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      rnd_q   <= 4'd0;
      mode_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_round_ctrl
//
// Scoreboard bench for aes_round_ctrl. The bench supplies two models:
//   - a key schedule that answers rk_req with randomly stalled rk_valid;
//   - a combinational AES round datapath that drives dp_result.
// When a block is accepted, its expected result goes into a queue. The
// expected result is a FIPS-197 constant or comes from a whole-cipher
// reference function. A monitor running on the falling edge pops the queue
// and compares on every output handshake. It also checks latency, the
// round-key order, stability during stalls and backpressure, and reset
// behaviour.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_aes_round_ctrl;

`ifdef AES_CTRL_DEC_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_mode;
  logic [0:127] in_data;
  logic         out_valid, out_ready;
  logic [0:127] out_data;
  logic         busy, rk_req, rk_valid;
  logic [3:0]   rk_idx;
  logic [0:127] rk_data, dp_state, dp_key, dp_result;
  logic         dp_inv, dp_last;

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .rk_req(rk_req), .rk_idx(rk_idx),
    .rk_valid(rk_valid), .rk_data(rk_data),
    .dp_state(dp_state), .dp_key(dp_key), .dp_inv(dp_inv), .dp_last(dp_last),
    .dp_result(dp_result)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- AES arithmetic (reference and datapath model) ----------
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [0:127] rks   [11];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // The S-box is built from its definition: the GF(2^8) inverse followed by
  // the affine transform.
  task automatic init_sbox();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (a != 0 && gmul(a[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[a] = s;
      isbox[s] = a[7:0];
    end
  endtask

  task automatic set_key(input logic [0:127] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [0:127] mix(input logic [0:127] x, input logic inv);
    logic [0:127] m;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = x[32*c +: 8]; a1 = x[32*c+8 +: 8]; a2 = x[32*c+16 +: 8]; a3 = x[32*c+24 +: 8];
      if (!inv) begin
        m[32*c    +: 8] = gmul(a0,2) ^ gmul(a1,3) ^ a2 ^ a3;
        m[32*c+8  +: 8] = a0 ^ gmul(a1,2) ^ gmul(a2,3) ^ a3;
        m[32*c+16 +: 8] = a0 ^ a1 ^ gmul(a2,2) ^ gmul(a3,3);
        m[32*c+24 +: 8] = gmul(a0,3) ^ a1 ^ a2 ^ gmul(a3,2);
      end else begin
        m[32*c    +: 8] = gmul(a0,14) ^ gmul(a1,11) ^ gmul(a2,13) ^ gmul(a3,9);
        m[32*c+8  +: 8] = gmul(a0,9) ^ gmul(a1,14) ^ gmul(a2,11) ^ gmul(a3,13);
        m[32*c+16 +: 8] = gmul(a0,13) ^ gmul(a1,9) ^ gmul(a2,14) ^ gmul(a3,11);
        m[32*c+24 +: 8] = gmul(a0,11) ^ gmul(a1,13) ^ gmul(a2,9) ^ gmul(a3,14);
      end
    end
    return m;
  endfunction

  // One (inverse) round: (Inv)ShiftRows and (Inv)SubBytes, then MixColumns
  // and the key for encrypt, or the key and InvMixColumns for decrypt.
  function automatic logic [0:127] aes_round(input logic [0:127] st, input logic [0:127] key,
                                             input logic inv, input logic last);
    logic [0:127] u;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!inv) u[8*(4*c+r) +: 8] = sbox[st[8*(4*((c+r)%4)+r) +: 8]];
        else      u[8*(4*c+r) +: 8] = isbox[st[8*(4*((c+4-r)%4)+r) +: 8]];
    if (!inv) return (last ? u : mix(u, 1'b0)) ^ key;
    u = u ^ key;
    return last ? u : mix(u, 1'b1);
  endfunction

  function automatic logic [0:127] aes_ref(input logic [0:127] blk, input logic dec);
    logic [0:127] s;
    s = blk ^ rks[dec ? 10 : 0];
    for (int r = 1; r <= 10; r++) s = aes_round(s, rks[dec ? 10 - r : r], dec, r == 10);
    return s;
  endfunction

  // Key-schedule and datapath models.
  assign rk_data = (rk_idx <= 4'd10) ? rks[rk_idx] : '0;
  always_comb dp_result = aes_round(dp_state, dp_key, dp_inv, dp_last);

  // ---------------- stimulus drivers ----------------------------------------
  typedef struct {
    logic [0:127] d;
    logic         m;
    logic [0:127] e;
  } item_t;

  item_t        in_q[$];
  logic [0:127] in_exp;
  int           stall_pct = 0;
  bit           or_hold = 0;
  bit           bp_rand = 0;

  task automatic push_blk(input logic [0:127] d, input logic m, input logic [0:127] e);
    item_t it;
    it.d = d; it.m = m; it.e = e;
    in_q.push_back(it);
  endtask

  initial begin : hs_drv
    rk_valid = 1'b0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rk_valid = ($urandom_range(0, 99) >= stall_pct);
      out_ready = or_hold ? 1'b0 : (bp_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  initial begin : in_drv
    in_valid = 1'b0; in_mode = 1'b0; in_data = '0; in_exp = '0;
    forever begin
      @(posedge clk); #1;
      if (in_q.size() > 0) begin
        in_valid = 1'b1; in_data = in_q[0].d; in_mode = in_q[0].m; in_exp = in_q[0].e;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready && rst_n) void'(in_q.pop_front());
    end
  end

  // ---------------- monitor / scoreboard ------------------------------------
  logic [0:127] exp_q[$];
  int           cyc = 0;
  int           acc_cyc = 0, stalls = 0, kcnt = 0, txn = 0;
  int           last_out_cyc = -1;
  bit           gap_chk = 0;
  bit           eff_mode = 0, prev_stall = 0, prev_bp = 0, seen_out = 0;
  logic [3:0]   prev_idx;
  logic [0:127] prev_data, e;
  int           exp_idx;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 0; prev_bp = 0; seen_out = 0; kcnt = 0; stalls = 0;
    end else begin
      if (rk_req) begin
        exp_idx = eff_mode ? 10 - kcnt : kcnt;
        if (prev_stall) check("rk_idx_stall", rk_idx, prev_idx);
        if (rk_valid) begin
          check("rk_idx", rk_idx, exp_idx);
          check("dp_last", dp_last, kcnt == 10);
          if (kcnt >= 1) check("dp_inv", dp_inv, eff_mode);
          kcnt++;
          prev_stall = 0;
        end else begin
          stalls++;
          prev_stall = 1;
          prev_idx = rk_idx;
        end
      end else begin
        if (prev_stall) check("rk_req_stall", rk_req, 1);
        prev_stall = 0;
      end

      if (out_valid) begin
        if (!seen_out) begin
          seen_out = 1;
          check("latency", cyc - (acc_cyc + 1), 11 + stalls);
          if (gap_chk && last_out_cyc >= 0) check("b2b_gap", cyc - last_out_cyc, 12);
          last_out_cyc = cyc;
        end
        if (prev_bp) check("out_hold", out_data, prev_data);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", out_valid, 0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e);
            $display("txn %0d out=%h exp=%h", txn, out_data, e);
          end
          prev_bp = 0;
          seen_out = 0;
        end else begin
          check("in_ready_bp", in_ready, 0);
          prev_bp = 1;
          prev_data = out_data;
        end
      end else begin
        if (prev_bp) check("out_valid_hold", out_valid, 1);
        prev_bp = 0;
      end

      if (in_valid && in_ready) begin
        exp_q.push_back(in_exp);
        acc_cyc = cyc;
        stalls = 0;
        kcnt = 0;
        eff_mode = DEC & in_mode;
        txn++;
      end
    end
  end

  // ---------------- sequencing ----------------------------------------------
  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (in_q.size() == 0 && exp_q.size() == 0 && !busy && !in_valid) return;
    end
    checks++; failures++;
    $display("FAIL wait_idle timeout busy=%0b pending=%0d", busy, exp_q.size());
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rk_req", rk_req, 0);
    check("rst_rk_idx", rk_idx, 0);
    check("rst_dp_inv", dp_inv, 0);
    check("rst_dp_last", dp_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_dp_state", dp_state, 0);
  endtask

  task automatic push_random(input int n);
    logic [0:127] d;
    logic m;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      push_blk(d, m, aes_ref(d, DEC & m));
    end
  endtask

  initial begin : main
    bit hit;
    init_sbox();
    set_key(C1_KEY);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // FIPS-197 C.1, no stalls, then a decrypt request on the ciphertext.
    push_blk(C1_PT, 1'b0, C1_CT);
    wait_idle();
    push_blk(C1_CT, 1'b1, DEC ? C1_PT : aes_ref(C1_CT, 1'b0));
    wait_idle();

    // 30% key stalls.
    stall_pct = 30;
    push_blk(C1_PT, 1'b0, C1_CT);
    push_random(4);
    wait_idle();

    // Backpressure for 5 cycles in DONE, with a second block waiting.
    stall_pct = 0;
    or_hold = 1;
    push_blk(C1_PT, 1'b0, C1_CT);
    push_random(1);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = out_valid;
    end
    if (!hit) begin
      checks++; failures++;
      $display("FAIL bp_wait timeout out_valid=%0b required=1", out_valid);
    end
    repeat (5) @(negedge clk);
    or_hold = 0;
    wait_idle();

    // Back-to-back blocks with out_ready high.
    last_out_cyc = -1;
    gap_chk = 1;
    push_random(3);
    wait_idle();
    gap_chk = 0;

    // New key, random stalls and random out_ready.
    set_key({$urandom, $urandom, $urandom, $urandom});
    stall_pct = 20;
    bp_rand = 1;
    push_random(6);
    wait_idle();
    bp_rand = 0;
    stall_pct = 0;

    // Reset while the block is in ROUND with rnd = 5.
    set_key(C1_KEY);
    push_blk(C1_PT, 1'b0, C1_CT);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = busy && (kcnt == 5);
    end
    if (!hit) begin
      checks++; failures++;
      $display("FAIL mid_reset_wait timeout kcnt=%0d required=5", kcnt);
    end
    #1 rst_n = 1'b0;
    in_q.delete();
    #1;
    check_reset_outputs();
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    push_blk(C1_PT, 1'b0, C1_CT);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
